id_issue_scheduler: RTL and testbench

- Multi-entry in-order buffer and dispatch scheduler between the decoder outputs and the issue stage.
- Replaces the single ID/issue pipeline register with a DEPTH-entry circular queue.
- Accepts up to NR_PORTS decoded instructions per cycle and releases up to NR_PORTS per cycle in program order.
- Enforces single-issue of control-flow instructions, honours macro-sequencer stalls and flushes.

---
 rtl/id_sched_pkg.sv | 24 ++
 rtl/id_issue_scheduler_if.sv | 26 ++
 rtl/id_sched_ring.sv | 51 +++++
 rtl/id_issue_scheduler.sv | 135 +++++++++++++
 tb/tb_id_issue_scheduler.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/id_sched_pkg.sv
// Shared types, sizing helpers and limits for the ID/issue scheduler slice.
package id_sched_pkg;

  localparam int ID_SCHED_MAX_PORTS = 2;
  localparam int ID_SCHED_ENTRY_W   = 128;

  typedef struct packed {
    logic                        ctrl_flow;
    logic [ID_SCHED_ENTRY_W-1:0] payload;
  } id_sched_slot_t;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] val);
    return (val == 32'hFFFF_FFFF) ? val : val + 32'd1;
  endfunction

endpackage

// File: rtl/id_issue_scheduler_if.sv
// Decode-side and issue-side handshake bundle of the ID/issue scheduler.
interface id_issue_scheduler_if #(
  parameter int NR_PORTS = id_sched_pkg::ID_SCHED_MAX_PORTS,
  parameter int ENTRY_W  = id_sched_pkg::ID_SCHED_ENTRY_W
);

  logic [NR_PORTS-1:0]         dec_valid_i;
  logic [NR_PORTS*ENTRY_W-1:0] dec_entry_i;
  logic [NR_PORTS-1:0]         dec_ctrl_flow_i;
  logic [NR_PORTS-1:0]         dec_ready_o;
  logic [NR_PORTS-1:0]         iss_valid_o;
  logic [NR_PORTS*ENTRY_W-1:0] iss_entry_o;
  logic [NR_PORTS-1:0]         iss_ctrl_flow_o;
  logic [NR_PORTS-1:0]         iss_ack_i;

  modport master (
    output dec_valid_i, dec_entry_i, dec_ctrl_flow_i, iss_ack_i,
    input  dec_ready_o, iss_valid_o, iss_entry_o, iss_ctrl_flow_o
  );

  modport slave (
    input  dec_valid_i, dec_entry_i, dec_ctrl_flow_i, iss_ack_i,
    output dec_ready_o, iss_valid_o, iss_entry_o, iss_ctrl_flow_o
  );

endinterface

// File: rtl/id_sched_ring.sv
// Circular slot storage with NR_PORTS consecutive write and read ports.
// Callers write lanes 0..wr_num_i-1 and retire rd_num_i slots per cycle.
module id_sched_ring
  import id_sched_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int NR_PORTS = 2
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           clr_i,
  input  logic [1:0]     wr_num_i,
  input  id_sched_slot_t wr_slot_i [NR_PORTS],
  input  logic [1:0]     rd_num_i,
  output id_sched_slot_t rd_slot_o [NR_PORTS]
);

  localparam int PW = ptr_w(DEPTH);
  typedef logic [PW-1:0] ptr_t;

  ptr_t           wr_ptr_q;
  ptr_t           rd_ptr_q;
  id_sched_slot_t mem_q [DEPTH];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its neighbours, whatever the block order.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + ptr_t'(wr_num_i);
      rd_ptr_q <= rd_ptr_q + ptr_t'(rd_num_i);
    end
  end

  // NOTE: the payload array has no reset; occupancy alone decides which
  // slots are meaningful, and a reset here would block RAM inference.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < NR_PORTS; k++) begin
      if (2'(k) < wr_num_i) begin
        mem_q[wr_ptr_q + ptr_t'(k)] <= wr_slot_i[k];
      end
    end
  end

  for (genvar k = 0; k < NR_PORTS; k++) begin : g_rd
    assign rd_slot_o[k] = mem_q[rd_ptr_q + ptr_t'(k)];
  end

endmodule

// File: rtl/id_issue_scheduler.sv
// In-order DEPTH-entry buffer between decode and issue, NR_PORTS lanes each way.
// Optional performance counters are built when ID_ISSUE_SCHED_PERF_EN is defined.
module id_issue_scheduler
  import id_sched_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int NR_PORTS = 2,
  parameter int ENTRY_W  = ID_SCHED_ENTRY_W
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    flush_i,
  input  logic                    stall_i,
  id_issue_scheduler_if.slave     bus,
  output logic [cnt_w(DEPTH)-1:0] occupancy_o
`ifdef ID_ISSUE_SCHED_PERF_EN
  ,
  output logic [31:0]             perf_full_cycles_o,
  output logic [31:0]             perf_ctrl_serial_o,
  output logic [31:0]             perf_dual_issue_o
`endif
);

  localparam int CW = cnt_w(DEPTH);
  typedef logic [CW-1:0] cnt_t;

  cnt_t                count_q;
  cnt_t                free;
  logic [NR_PORTS-1:0] ready;
  logic [NR_PORTS-1:0] acc;
  logic [NR_PORTS-1:0] iss_valid;
  logic [NR_PORTS-1:0] ack_eff;
  logic [1:0]          acc_num;
  logic [1:0]          ack_num;
  id_sched_slot_t      wr_slot [NR_PORTS];
  id_sched_slot_t      rd_slot [NR_PORTS];

  // Space is judged on the registered count; acks this cycle free nothing yet.
  assign free         = cnt_t'(DEPTH) - count_q;
  assign ready[0]     = !rst_i && !stall_i && !flush_i && (free != '0);
  assign iss_valid[0] = (count_q != '0);
  assign ack_eff[0]   = !flush_i && bus.iss_ack_i[0] && iss_valid[0];

  if (NR_PORTS > 1) begin : g_lane1
    // Lane 1 only follows an accepted lane 0; a control-flow head issues alone.
    assign ready[1]     = ready[0] && bus.dec_valid_i[0] && (free >= cnt_t'(2));
    assign iss_valid[1] = (count_q >= cnt_t'(2)) && !rd_slot[0].ctrl_flow;
    assign ack_eff[1]   = ack_eff[0] && bus.iss_ack_i[1] && iss_valid[1];
  end

  assign acc = bus.dec_valid_i & ready;

  // NOTE: combinational blocks start from a default for every output so no
  // path leaves a signal unassigned and a latch gets inferred.
  always_comb begin
    acc_num = '0;
    ack_num = '0;
    for (int k = 0; k < NR_PORTS; k++) begin
      acc_num = acc_num + 2'(acc[k]);
      ack_num = ack_num + 2'(ack_eff[k]);
    end
  end

  for (genvar k = 0; k < NR_PORTS; k++) begin : g_lane
    assign wr_slot[k] = '{ctrl_flow: bus.dec_ctrl_flow_i[k],
                          payload:   bus.dec_entry_i[k*ENTRY_W +: ENTRY_W]};
    assign bus.iss_entry_o[k*ENTRY_W +: ENTRY_W] = rd_slot[k].payload;
    assign bus.iss_ctrl_flow_o[k]                = rd_slot[k].ctrl_flow;
  end

  assign bus.dec_ready_o = ready;
  assign bus.iss_valid_o = iss_valid;
  assign occupancy_o     = count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + cnt_t'(acc_num) - cnt_t'(ack_num);
    end
  end

  id_sched_ring #(
    .DEPTH    (DEPTH),
    .NR_PORTS (NR_PORTS)
  ) u_ring (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (flush_i),
    .wr_num_i  (acc_num),
    .wr_slot_i (wr_slot),
    .rd_num_i  (ack_num),
    .rd_slot_o (rd_slot)
  );

`ifdef ID_ISSUE_SCHED_PERF_EN
  logic [31:0] perf_full_q;
  logic [31:0] perf_serial_q;
  logic [31:0] perf_dual_q;

  // Flush leaves the statistics intact; only reset clears them.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_full_q   <= '0;
      perf_serial_q <= '0;
      perf_dual_q   <= '0;
    end else begin
      if ((count_q == cnt_t'(DEPTH)) && bus.dec_valid_i[0]) perf_full_q <= sat_inc(perf_full_q);
      if ((count_q >= cnt_t'(2)) && rd_slot[0].ctrl_flow) perf_serial_q <= sat_inc(perf_serial_q);
      if (ack_num == 2'd2) perf_dual_q <= sat_inc(perf_dual_q);
    end
  end

  assign perf_full_cycles_o = perf_full_q;
  assign perf_ctrl_serial_o = perf_serial_q;
  assign perf_dual_issue_o  = perf_dual_q;
`endif

  a_count_bound : assert property (@(posedge clk_i) disable iff (rst_i)
    count_q <= cnt_t'(DEPTH));

  for (genvar k = 0; k < NR_PORTS; k++) begin : g_chk
    a_ack_valid : assert property (@(posedge clk_i) disable iff (rst_i)
      bus.iss_ack_i[k] |-> iss_valid[k]);
    a_entry_stable : assert property (@(posedge clk_i) disable iff (rst_i)
      (iss_valid[k] && (ack_num == 2'd0) && !flush_i)
        |=> $stable(bus.iss_entry_o[k*ENTRY_W +: ENTRY_W]));
  end

  if (NR_PORTS > 1) begin : g_chk_order
    a_ack_order : assert property (@(posedge clk_i) disable iff (rst_i)
      bus.iss_ack_i[1] |-> bus.iss_ack_i[0]);
  end

endmodule

// File: tb/tb_id_issue_scheduler.sv
// Self-checking bench for id_issue_scheduler: directed vector table, a wrap
// sequence with a scoreboard, and random traffic against a queue model.
module tb_id_issue_scheduler;
  import id_sched_pkg::*;

  localparam int DEPTH    = 4;
  localparam int NR_PORTS = 2;
  localparam int ENTRY_W  = ID_SCHED_ENTRY_W;

  logic       clk = 1'b0;
  logic       rst;
  logic       flush;
  logic       stall;
  logic [2:0] occupancy;

  id_issue_scheduler_if #(.NR_PORTS(NR_PORTS), .ENTRY_W(ENTRY_W)) bus ();

`ifdef ID_ISSUE_SCHED_PERF_EN
  logic [31:0] perf_full, perf_serial, perf_dual;
`endif

  id_issue_scheduler #(
    .DEPTH    (DEPTH),
    .NR_PORTS (NR_PORTS),
    .ENTRY_W  (ENTRY_W)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (flush),
    .stall_i     (stall),
    .bus         (bus),
    .occupancy_o (occupancy)
`ifdef ID_ISSUE_SCHED_PERF_EN
    ,
    .perf_full_cycles_o (perf_full),
    .perf_ctrl_serial_o (perf_serial),
    .perf_dual_issue_o  (perf_dual)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] mk(input int t);
    return {32'(t), ~32'(t), 32'(t) ^ 32'hA5A5_5A5A, 32'(t * 7 + 1)};
  endfunction

  task automatic drive(input logic r, input logic f, input logic s,
                       input logic [1:0] dv, input logic [1:0] cf, input logic [1:0] ack,
                       input logic [127:0] p0, input logic [127:0] p1);
    rst                 = r;
    flush               = f;
    stall               = s;
    bus.dec_valid_i     = dv;
    bus.dec_ctrl_flow_i = cf;
    bus.iss_ack_i       = ack;
    bus.dec_entry_i     = {p1, p0};
  endtask

  typedef struct {
    logic       r, f, s;
    logic [1:0] dv, cf, ack;
    int         t0, t1;
    logic [1:0] e_rdy, e_vld, e_icf;
    int         e_occ, e_s0, e_s1;
  } vec_t;

  function automatic vec_t v(input logic r, input logic f, input logic s,
                             input logic [1:0] dv, input logic [1:0] cf, input logic [1:0] ack,
                             input int t0, input int t1,
                             input logic [1:0] e_rdy, input logic [1:0] e_vld, input logic [1:0] e_icf,
                             input int e_occ, input int e_s0, input int e_s1);
    return '{r, f, s, dv, cf, ack, t0, t1, e_rdy, e_vld, e_icf, e_occ, e_s0, e_s1};
  endfunction

  typedef struct {
    logic         cf;
    logic [127:0] p;
  } item_t;

  item_t       mq[$];
  logic [31:0] sb[$];
  vec_t        tv[20];

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wr_tag;
    int issued;

    // Directed cycles; slot tags of 0 mean "not compared".
    //        r  f  s  dv     cf     ack    t0  t1  rdy    vld    icf    occ s0  s1
    tv[0]  = v(0, 0, 0, 2'b11, 2'b00, 2'b00, 1,  2,  2'b11, 2'b00, 2'b00, 0,  0,  0);
    tv[1]  = v(0, 0, 0, 2'b00, 2'b00, 2'b11, 0,  0,  2'b01, 2'b11, 2'b00, 2,  1,  2);
    tv[2]  = v(0, 0, 0, 2'b11, 2'b01, 2'b00, 3,  4,  2'b11, 2'b00, 2'b00, 0,  0,  0);
    tv[3]  = v(0, 0, 0, 2'b00, 2'b00, 2'b01, 0,  0,  2'b01, 2'b01, 2'b01, 2,  3,  0);
    tv[4]  = v(0, 0, 0, 2'b00, 2'b00, 2'b00, 0,  0,  2'b01, 2'b01, 2'b00, 1,  4,  0);
    tv[5]  = v(0, 0, 0, 2'b11, 2'b00, 2'b00, 5,  6,  2'b11, 2'b01, 2'b00, 1,  4,  0);
    tv[6]  = v(0, 0, 0, 2'b01, 2'b00, 2'b00, 7,  0,  2'b01, 2'b11, 2'b00, 3,  4,  5);
    tv[7]  = v(0, 0, 0, 2'b11, 2'b00, 2'b01, 8,  9,  2'b00, 2'b11, 2'b00, 4,  4,  5);
    tv[8]  = v(0, 0, 0, 2'b11, 2'b00, 2'b00, 8,  9,  2'b01, 2'b11, 2'b00, 3,  5,  6);
    tv[9]  = v(0, 0, 0, 2'b00, 2'b00, 2'b01, 0,  0,  2'b00, 2'b11, 2'b00, 4,  5,  6);
    tv[10] = v(0, 1, 0, 2'b11, 2'b00, 2'b11, 10, 11, 2'b00, 2'b11, 2'b00, 3,  6,  7);
    tv[11] = v(0, 0, 0, 2'b00, 2'b00, 2'b00, 0,  0,  2'b01, 2'b00, 2'b00, 0,  0,  0);
    tv[12] = v(0, 0, 1, 2'b01, 2'b00, 2'b00, 12, 0,  2'b00, 2'b00, 2'b00, 0,  0,  0);
    tv[13] = v(0, 0, 0, 2'b01, 2'b00, 2'b00, 12, 0,  2'b11, 2'b00, 2'b00, 0,  0,  0);
    tv[14] = v(0, 0, 0, 2'b11, 2'b00, 2'b00, 13, 14, 2'b11, 2'b01, 2'b00, 1,  12, 0);
    tv[15] = v(1, 0, 0, 2'b11, 2'b00, 2'b00, 30, 31, 2'b00, 2'b11, 2'b00, 3,  12, 13);
    tv[16] = v(0, 0, 0, 2'b00, 2'b00, 2'b00, 0,  0,  2'b01, 2'b00, 2'b00, 0,  0,  0);
    tv[17] = v(0, 0, 0, 2'b11, 2'b10, 2'b00, 15, 16, 2'b11, 2'b00, 2'b00, 0,  0,  0);
    tv[18] = v(0, 0, 0, 2'b00, 2'b00, 2'b11, 0,  0,  2'b01, 2'b11, 2'b10, 2,  15, 16);
    tv[19] = v(0, 0, 0, 2'b00, 2'b00, 2'b00, 0,  0,  2'b01, 2'b00, 2'b00, 0,  0,  0);

    drive(1'b1, 1'b0, 1'b0, 2'b11, 2'b00, 2'b00, mk(90), mk(91));
    @(negedge clk);
    #1;
    check("reset_ready", bus.dec_ready_o, 2'b00);

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      drive(tv[i].r, tv[i].f, tv[i].s, tv[i].dv, tv[i].cf, tv[i].ack, mk(tv[i].t0), mk(tv[i].t1));
      #1;
      check($sformatf("row%0d_ready", i), bus.dec_ready_o, tv[i].e_rdy);
      check($sformatf("row%0d_valid", i), bus.iss_valid_o, tv[i].e_vld);
      check($sformatf("row%0d_occ", i), occupancy, 128'(tv[i].e_occ));
      check($sformatf("row%0d_cflow", i), bus.iss_ctrl_flow_o & tv[i].e_vld, tv[i].e_icf);
      if (tv[i].e_s0 != 0) check($sformatf("row%0d_slot0", i), bus.iss_entry_o[127:0], mk(tv[i].e_s0));
      if (tv[i].e_s1 != 0) check($sformatf("row%0d_slot1", i), bus.iss_entry_o[255:128], mk(tv[i].e_s1));
    end

    // Six single-lane writes with acks on alternate cycles; pointers start at 2.
    wr_tag = 20;
    issued = 0;
    for (int cyc = 0; cyc < 40 && issued < 6; cyc++) begin
      logic [1:0] a;
      logic       wv;
      logic       acc_exp;
      @(negedge clk);
      wv = (wr_tag < 26);
      a  = ((cyc % 2) == 1 && sb.size() > 0) ? 2'b01 : 2'b00;
      drive(1'b0, 1'b0, 1'b0, {1'b0, wv}, 2'b00, a, mk(wr_tag), mk(99));
      #1;
      if (a[0]) begin
        check("wrap_valid", bus.iss_valid_o[0], 1);
        check("wrap_order", bus.iss_entry_o[127:0], mk(int'(sb[0])));
      end
      acc_exp = wv && (sb.size() < DEPTH);
      @(posedge clk);
      if (a[0]) begin
        void'(sb.pop_front());
        issued++;
      end
      if (acc_exp) begin
        sb.push_back(32'(wr_tag));
        wr_tag++;
      end
    end
    check("wrap_issued", 128'(issued), 6);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, '0, '0);
    #1;
    check("wrap_empty_occ", occupancy, 0);
    check("wrap_empty_valid", bus.iss_valid_o, 2'b00);

    // Random traffic against a queue model of the buffer contents.
    for (int i = 0; i < 1500; i++) begin
      logic         r, f, s, ev0, ev1, er0, er1;
      logic [1:0]   dv, cf, ack;
      logic [127:0] p0, p1;
      int           mfree, nack;
      @(negedge clk);
      r     = (i == 0) || ($urandom_range(0, 199) == 0);
      f     = ($urandom_range(0, 49) == 0);
      s     = ($urandom_range(0, 4) == 0);
      dv    = 2'($urandom_range(0, 3));
      cf[0] = ($urandom_range(0, 3) == 0);
      cf[1] = ($urandom_range(0, 3) == 0);
      p0    = {$urandom(), $urandom(), $urandom(), $urandom()};
      p1    = {$urandom(), $urandom(), $urandom(), $urandom()};
      mfree = DEPTH - mq.size();
      ev0   = (mq.size() >= 1);
      ev1   = (mq.size() >= 2) && !mq[0].cf;
      ack[0] = ev0 && ($urandom_range(0, 2) != 0);
      ack[1] = ack[0] && ev1 && ($urandom_range(0, 1) == 1);
      er0   = !r && !s && !f && (mfree >= 1);
      er1   = er0 && dv[0] && (mfree >= 2);
      drive(r, f, s, dv, cf, ack, p0, p1);
      #1;
      if (i > 0) begin
        check("rnd_ready", bus.dec_ready_o, {er1, er0});
        check("rnd_valid", bus.iss_valid_o, {ev1, ev0});
        check("rnd_occ", occupancy, 128'(mq.size()));
        if (ev0) check("rnd_slot0", {bus.iss_ctrl_flow_o[0], bus.iss_entry_o[127:0]}, {mq[0].cf, mq[0].p});
        if (ev1) check("rnd_slot1", {bus.iss_ctrl_flow_o[1], bus.iss_entry_o[255:128]}, {mq[1].cf, mq[1].p});
      end
      @(posedge clk);
      if (r || f) begin
        mq.delete();
      end else begin
        nack = (ack[0] && ev0) ? ((ack[1] && ev1) ? 2 : 1) : 0;
        repeat (nack) void'(mq.pop_front());
        if (dv[0] && er0) mq.push_back('{cf[0], p0});
        if (dv[1] && er1) mq.push_back('{cf[1], p1});
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
